// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the D-stage branch resolution controller:
// branch op codes, FSM state encoding, link/target offsets and the
// branch target helper.
package branch_resolve_ctrl_pkg;

    localparam logic [4:0]  OP_BEQ    = 5'h04;
    localparam logic [4:0]  OP_BNE    = 5'h05;
    localparam logic [4:0]  OP_BGEZAL = 5'h11;

    localparam logic [31:0] PC_NEXT_OFFSET = 32'd4;
    localparam logic [31:0] LINK_OFFSET    = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_REDIRECT  = 2'd2
    } br_state_e;

    // pc + 4 + (sext(imm) << 2), wrapping at 32 bits
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] imm);
        return pc + PC_NEXT_OFFSET + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_cond_eval.sv
// br_cond_eval: combinational branch condition evaluation.
// Ports:
//   op_i      branch op code
//   opa_i     rs operand
//   opb_i     rt operand
//   taken_o   branch condition holds
//   is_link_o op writes the link register ($31)
// Unknown op codes resolve as not taken, no link.
module br_cond_eval
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    output logic        taken_o,
    output logic        is_link_o
);

    always_comb begin
        taken_o   = 1'b0;
        is_link_o = 1'b0;
        case (op_i)
            OP_BEQ:    taken_o = (opa_i == opb_i);
            OP_BNE:    taken_o = (opa_i != opb_i);
            OP_BGEZAL: begin
                taken_o   = ~opa_i[31];
                is_link_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences D-stage branch resolution. Accepts one
// branch, waits for both forwarded operands, evaluates the condition,
// redirects fetch over a valid/ready handshake and pulses the $31 link
// write for bgezal. The front end is stalled while a branch is pending.
//
// Ports:
//   clk, reset_n                    core clock, async active-low reset
//   req_valid/req_ready             branch request handshake (op, pc, imm16)
//   opA_data/opA_rdy, opB_*         forwarded operands and their final flags
//   flush                           synchronous abandon of any in-flight branch
//   stall                           freeze F/D while not idle
//   redir_valid/redir_ready/redir_pc  taken-branch redirect to fetch
//   link_valid/link_pc              one-cycle $31 write (bgezal)
//   err                             one-cycle pulse on operand wait timeout
//   stat_resolved/stat_taken        statistics counters
//
// Optional feature: define BRANCH_STATS_EN to build the statistics counters;
// otherwise both stat outputs are tied to zero.
//
// state        | meaning
// ST_IDLE      | ready for a new branch request
// ST_WAIT_OPND | branch latched, waiting for both operands ready
// ST_REDIRECT  | taken branch, redirect offered to fetch
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_pc,
    input  logic [15:0] req_imm16,
    input  logic [31:0] opA_data,
    input  logic        opA_rdy,
    input  logic [31:0] opB_data,
    input  logic        opB_rdy,
    input  logic        flush,
    output logic        stall,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        link_valid,
    output logic [31:0] link_pc,
    output logic        err,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_taken
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    br_state_e         state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [4:0]        op_q, op_d;
    logic [31:0]       redir_pc_q, redir_pc_d;
    logic [31:0]       link_pc_q, link_pc_d;
    logic              link_q, link_d;
    logic              err_q, err_d;
    logic              cond_taken, cond_is_link;
    logic              opnd_rdy;

    br_cond_eval u_cond_eval (
        .op_i      (op_q),
        .opa_i     (opA_data),
        .opb_i     (opB_data),
        .taken_o   (cond_taken),
        .is_link_o (cond_is_link)
    );

    assign opnd_rdy = opA_rdy & opB_rdy;

    // Wait timer counts down the remaining not-ready cycles; expiry at zero
    // happens on the WAIT_LIMIT-th cycle without both operands ready.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        redir_pc_d = redir_pc_q;
        link_pc_d  = link_pc_q;
        link_d     = 1'b0;
        err_d      = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_d    = ST_WAIT_OPND;
                        op_d       = req_op;
                        redir_pc_d = branch_target(req_pc, req_imm16);
                        link_pc_d  = req_pc + LINK_OFFSET;
                        wait_cnt_d = CNT_W'(WAIT_LIMIT - 1);
                    end
                end
                ST_WAIT_OPND: begin
                    if (opnd_rdy) begin
                        link_d  = cond_is_link;
                        state_d = cond_taken ? ST_REDIRECT : ST_IDLE;
                    end else if (wait_cnt_q == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - CNT_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    if (redir_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            op_q       <= '0;
            redir_pc_q <= '0;
            link_pc_q  <= '0;
            link_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            redir_pc_q <= redir_pc_d;
            link_pc_q  <= link_pc_d;
            link_q     <= link_d;
            err_q      <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign stall       = (state_q != ST_IDLE);
    assign redir_valid = (state_q == ST_REDIRECT);
    assign redir_pc    = redir_pc_q;
    assign link_valid  = link_q;
    assign link_pc     = link_pc_q;
    assign err         = err_q;

`ifdef BRANCH_STATS_EN
    logic        eval_fire;
    logic [31:0] stat_res_q, stat_tak_q;

    assign eval_fire = (state_q == ST_WAIT_OPND) & opnd_rdy & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_res_q <= '0;
            stat_tak_q <= '0;
        end else if (eval_fire) begin
            stat_res_q <= stat_res_q + 32'd1;
            if (cond_taken) stat_tak_q <= stat_tak_q + 32'd1;
        end
    end

    assign stat_resolved = stat_res_q;
    assign stat_taken    = stat_tak_q;
`else
    assign stat_resolved = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed scenarios plus randomized
// branches checked against a transaction-level reference model.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    localparam int WAIT_LIMIT = 16;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_pc;
    logic [15:0] req_imm16;
    logic [31:0] opA_data, opB_data;
    logic        opA_rdy, opB_rdy;
    logic        flush, stall;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;
    logic        link_valid;
    logic [31:0] link_pc;
    logic        err;
    logic [31:0] stat_resolved, stat_taken;

    int n_tests = 0;
    int n_fail  = 0;
    int m_res   = 0;
    int m_tak   = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_pc       (req_pc),
        .req_imm16    (req_imm16),
        .opA_data     (opA_data),
        .opA_rdy      (opA_rdy),
        .opB_data     (opB_data),
        .opB_rdy      (opB_rdy),
        .flush        (flush),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .link_valid   (link_valid),
        .link_pc      (link_pc),
        .err          (err),
        .stat_resolved(stat_resolved),
        .stat_taken   (stat_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".stat_res"}, stat_resolved, STATS ? 32'(m_res) : 32'd0);
        check({tag, ".stat_tak"}, stat_taken,    STATS ? 32'(m_tak) : 32'd0);
    endtask

    // One branch from an idle negedge to an idle negedge.
    //   opnd_delay : wait cycles with operands not both ready (>= WAIT_LIMIT -> timeout)
    //   flush_wait : wait cycle index at which flush is raised (-1 none)
    //   rdy_delay  : REDIRECT cycles before redir_ready (or flush if flush_redir)
    task automatic run_branch(input string tag, input logic [4:0] op,
                              input logic [31:0] pc, input logic [15:0] imm,
                              input logic [31:0] a, input logic [31:0] b,
                              input int opnd_delay, input int flush_wait,
                              input int rdy_delay, input bit flush_redir,
                              output int stall_cycles);
        bit taken, link, timed_out, flushed;
        logic [31:0] tgt, lpc;
        int simm;

        simm = int'($signed(imm));
        tgt  = pc + 32'd4 + 32'(simm * 4);
        lpc  = pc + 32'd8;
        link = (op == OP_BGEZAL);
        case (op)
            OP_BEQ:    taken = (a == b);
            OP_BNE:    taken = (a != b);
            OP_BGEZAL: taken = ($signed(a) >= 0);
            default:   taken = 1'b0;
        endcase

        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_pc = pc; req_imm16 = imm;
        opA_rdy = 1'b0; opB_rdy = 1'b0;
        step();
        req_valid = 1'b0;
        req_op = 5'($urandom); req_pc = $urandom; req_imm16 = 16'($urandom);

        stall_cycles = 0; flushed = 0; timed_out = 0;
        for (int k = 0; k <= WAIT_LIMIT; k++) begin
            check({tag, ".wait_stall"}, {31'd0, stall}, 32'd1);
            check({tag, ".wait_redir"}, {31'd0, redir_valid}, 32'd0);
            if (stall) stall_cycles++;
            if (k >= opnd_delay) begin
                opA_data = a; opB_data = b; opA_rdy = 1'b1; opB_rdy = 1'b1;
            end else begin
                opA_data = $urandom; opB_data = $urandom;
                opA_rdy = 1'($urandom_range(0, 1));
                opB_rdy = opA_rdy ? 1'b0 : 1'($urandom_range(0, 1));
            end
            flush = (k == flush_wait);
            step();
            flush = 1'b0; opA_rdy = 1'b0; opB_rdy = 1'b0;
            if (k == flush_wait) begin flushed = 1; break; end
            if (k >= opnd_delay) break;
            if (k == WAIT_LIMIT - 1) begin timed_out = 1; break; end
        end

        if (flushed) begin
            check({tag, ".fl_stall"}, {31'd0, stall}, 32'd0);
            check({tag, ".fl_redir"}, {31'd0, redir_valid}, 32'd0);
            check({tag, ".fl_link"},  {31'd0, link_valid}, 32'd0);
            check({tag, ".fl_err"},   {31'd0, err}, 32'd0);
        end else if (timed_out) begin
            check({tag, ".to_err"},   {31'd0, err}, 32'd1);
            check({tag, ".to_stall"}, {31'd0, stall}, 32'd0);
            check({tag, ".to_redir"}, {31'd0, redir_valid}, 32'd0);
            check({tag, ".to_link"},  {31'd0, link_valid}, 32'd0);
            step();
            check({tag, ".err_pulse"}, {31'd0, err}, 32'd0);
        end else begin
            m_res++;
            if (taken) m_tak++;
            check({tag, ".link_valid"}, {31'd0, link_valid}, {31'd0, link});
            if (link) check({tag, ".link_pc"}, link_pc, lpc);
            check({tag, ".redir_valid"}, {31'd0, redir_valid}, {31'd0, taken});
            check({tag, ".stall"}, {31'd0, stall}, {31'd0, taken});
            check({tag, ".err"}, {31'd0, err}, 32'd0);
            if (taken) begin
                for (int j = 0; j <= rdy_delay; j++) begin
                    check({tag, ".rd_valid"}, {31'd0, redir_valid}, 32'd1);
                    check({tag, ".rd_pc"}, redir_pc, tgt);
                    if (j > 0) check({tag, ".link_pulse"}, {31'd0, link_valid}, 32'd0);
                    redir_ready = (j == rdy_delay) && !flush_redir;
                    flush       = (j == rdy_delay) && flush_redir;
                    step();
                    redir_ready = 1'b0; flush = 1'b0;
                end
                check({tag, ".rd_done"}, {31'd0, redir_valid}, 32'd0);
                check({tag, ".rd_stall"}, {31'd0, stall}, 32'd0);
                check({tag, ".rd_link"}, {31'd0, link_valid}, 32'd0);
            end else if (link) begin
                step();
                check({tag, ".link_pulse"}, {31'd0, link_valid}, 32'd0);
            end
        end
        check_stats(tag);
    endtask

    initial begin
        int sc;
        logic [4:0]  op;
        logic [31:0] a, b;
        int dly, fw;

        reset_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_pc = '0; req_imm16 = '0;
        opA_data = '0; opB_data = '0; opA_rdy = 1'b0; opB_rdy = 1'b0;
        flush = 1'b0; redir_ready = 1'b0;
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.stall", {31'd0, stall}, 32'd0);
        check("rst.redir_valid", {31'd0, redir_valid}, 32'd0);
        check("rst.link_valid", {31'd0, link_valid}, 32'd0);
        check("rst.err", {31'd0, err}, 32'd0);
        check("rst.redir_pc", redir_pc, 32'd0);
        check("rst.link_pc", link_pc, 32'd0);
        check_stats("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_branch("beq_taken", OP_BEQ, 32'h3000, 16'h0004, 32'h1234, 32'h1234, 0, -1, 0, 0, sc);
        check("beq_taken.target_const", redir_pc, 32'h0000_3014);
        run_branch("bne_equal", OP_BNE, 32'h4000, 16'h0010, 32'd5, 32'd5, 0, -1, 0, 0, sc);
        check("bne_equal.stall_cycles", 32'(sc), 32'd1);
        run_branch("bgezal_neg", OP_BGEZAL, 32'h5000, 16'hFFFE, 32'hFFFF_FFFF, 32'd0, 0, -1, 0, 0, sc);
        run_branch("bgezal_zero", OP_BGEZAL, 32'h5100, 16'h8000, 32'd0, 32'd7, 0, -1, 1, 0, sc);
        run_branch("beq_late_b", OP_BEQ, 32'h6000, 16'hFFFF, 32'hCAFE, 32'hCAFE, 3, -1, 0, 0, sc);
        check("beq_late_b.stall_cycles", 32'(sc), 32'd4);
        run_branch("timeout", OP_BEQ, 32'h7000, 16'h0001, 32'd1, 32'd1, 100, -1, 0, 0, sc);
        check("timeout.stall_cycles", 32'(sc), 32'(WAIT_LIMIT));
        run_branch("redir_flush", OP_BNE, 32'h8000, 16'h0020, 32'd1, 32'd2, 0, -1, 2, 1, sc);
        run_branch("wrap", OP_BEQ, 32'hFFFF_FFF8, 16'h0001, 32'd0, 32'd0, 0, -1, 0, 0, sc);
        run_branch("flush_eval", OP_BGEZAL, 32'h9000, 16'h0003, 32'd4, 32'd0, 1, 1, 0, 0, sc);

        // request coincident with flush is ignored
        req_valid = 1'b1; req_op = OP_BEQ; req_pc = 32'hA000; req_imm16 = 16'd1; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_req.stall", {31'd0, stall}, 32'd0);
        check("flush_req.ready", {31'd0, req_ready}, 32'd1);

        // async reset in the middle of an operand wait
        req_valid = 1'b1; req_op = OP_BEQ; req_pc = 32'hB000; req_imm16 = 16'd2;
        step();
        req_valid = 1'b0;
        check("arst.pre_link_pc", link_pc, 32'hB008);
        #2 reset_n = 1'b0;
        #1;
        check("arst.stall", {31'd0, stall}, 32'd0);
        check("arst.redir_pc", redir_pc, 32'd0);
        check("arst.link_pc", link_pc, 32'd0);
        m_res = 0; m_tak = 0;
        @(negedge clk);
        reset_n = 1'b1;
        opA_rdy = 1'b1; opB_rdy = 1'b1;
        step();
        opA_rdy = 1'b0; opB_rdy = 1'b0;
        check("arst.redir_valid", {31'd0, redir_valid}, 32'd0);
        check("arst.link_valid", {31'd0, link_valid}, 32'd0);
        check_stats("arst");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: op = OP_BEQ;
                1: op = OP_BNE;
                2: op = OP_BGEZAL;
                default: begin
                    op = 5'($urandom);
                    if (op == OP_BEQ || op == OP_BNE || op == OP_BGEZAL) op = 5'h00;
                end
            endcase
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            dly = ($urandom_range(0, 9) == 0) ? WAIT_LIMIT + $urandom_range(0, 3) : $urandom_range(0, 4);
            fw  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            run_branch("rand", op, $urandom, 16'($urandom), a, b, dly, fw,
                       $urandom_range(0, 3), ($urandom_range(0, 7) == 0), sc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
